uart_rx_os: RTL and testbench



---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx_os.sv | 144 ++++++++++++++
 tb/tb_uart_rx_os.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and rx state type; ST_PARITY exists only with UART_RX_PARITY_EN
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to the idle (high) level
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// rtl/uart_rx_os.sv - oversampled UART receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int NUM_CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int            CW        = $clog2(NUM_CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(NUM_CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(NUM_CLKS_PER_BIT - 1);

    rx_state_t            state;
    logic [CW-1:0]        clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 bit_tick;
    logic                 par_bad;

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign bit_tick = (clk_cnt == BIT_LAST);
    assign busy     = (state != ST_IDLE);

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic perr_q;
    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad    = ^{shreg, par_bit};
    assign parity_err = perr_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
            clk_cnt   <= clk_cnt + CW'(1);
            case (state)
                ST_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                    end
                end
                ST_START: begin
                    // Mid-start-bit recheck rejects short glitches without any pulse.
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        par_bit <= rx_s;
                        state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= ST_IDLE;
                            if (!par_bad) begin
                                dout <= shreg;
                                done <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            perr_q <= par_bad;
`endif
                        end else begin
                            // Line still low: hold off until it recovers so a break reports once.
                            state     <= ST_WAIT_HIGH;
                            frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_q    <= par_bad;
`endif
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    clk_cnt <= '0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb/tb_uart_rx_os.sv - randomized self-checking bench for uart_rx_os against a frame-level event model
module tb_uart_rx_os;

    localparam int N = 16;
    localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    // rx falls -> 2 sync flops -> IDLE sees it -> half bit -> 8 data (+ parity) + stop bit times
    localparam int LAT = 3 + H + (9 + P) * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dout;
    logic       done;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_os #(.NUM_CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .dout       (dout),
        .done       (done),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        bit         good;
        bit         ferr;
        bit         perr;
        logic [7:0] data;
    } ev_t;

    ev_t        evq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_dout = 8'h00;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         last_done_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        ev_t ev;
        bit  e_done;
        bit  e_ferr;
        bit  e_perr;
        e_done = 1'b0;
        e_ferr = 1'b0;
        e_perr = 1'b0;
        if (rst) begin
            model_dout = 8'h00;
            evq.delete();
        end
        while (evq.size() > 0 && evq[0].at < cyc) void'(evq.pop_front());
        if (evq.size() > 0 && evq[0].at == cyc) begin
            ev     = evq.pop_front();
            e_done = ev.good;
            e_ferr = ev.ferr;
            e_perr = ev.perr;
            if (ev.good) model_dout = ev.data;
        end
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (parity_err === 1'b1) perr_cnt++;
        check("done", {31'd0, done}, {31'd0, e_done});
        check("frame_err", {31'd0, frame_err}, {31'd0, e_ferr});
        check("parity_err", {31'd0, parity_err}, {31'd0, e_perr});
        if (!rst) check("dout", {24'd0, dout}, {24'd0, model_dout});
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (N) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok);
        ev_t  ev;
        logic pb;
        logic bad;
        pb  = (^d) ^ ~par_ok;
        bad = (P == 1) && !par_ok;
        ev.at   = cyc + LAT;
        ev.good = stop && !bad;
        ev.ferr = !stop;
        ev.perr = bad;
        ev.data = d;
        evq.push_back(ev);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(pb);
`endif
        drive_bit(stop);
    endtask

    initial begin
        int c0;
        int dc;
        int fc;
        int pc;
        int gap;
        logic st;
        logic pok;
        logic [7:0] d;

        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_dout", {24'd0, dout}, 32'h00);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_perr", {31'd0, parity_err}, 32'd0);
        idle(N);

        // Scenario 1: plain 0xA5
        c0 = cyc; dc = done_cnt; fc = ferr_cnt; pc = perr_cnt;
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2 * N);
        check("s1_done_count", done_cnt - dc, 32'd1);
        check("s1_dout", {24'd0, dout}, 32'hA5);
        check("s1_no_err", (ferr_cnt - fc) + (perr_cnt - pc), 32'd0);
`ifdef UART_RX_PARITY_EN
        check("s1_latency", last_done_cyc - c0, 32'd171);
`else
        check("s1_latency", last_done_cyc - c0, 32'd155);
`endif

        // Scenario 2: 4-clock glitch
        dc = done_cnt; fc = ferr_cnt; pc = perr_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        check("s2_busy_in_start", {31'd0, busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("s2_busy_back", {31'd0, busy}, 32'd0);
        idle(N);
        check("s2_no_pulse", (done_cnt - dc) + (ferr_cnt - fc) + (perr_cnt - pc), 32'd0);

        // Scenario 3: 0x3C with low stop, then break, then 0x11
        dc = done_cnt; fc = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (5 * N) @(posedge clk);
        #1;
        idle(2 * N);
        check("s3_one_ferr", ferr_cnt - fc, 32'd1);
        check("s3_no_done", done_cnt - dc, 32'd0);
        check("s3_dout_kept", {24'd0, dout}, 32'hA5);
        send_frame(8'h11, 1'b1, 1'b1);
        idle(2 * N);
        check("s3_dout_next", {24'd0, dout}, 32'h11);

        // Scenario 4: back-to-back 0x00, 0xFF
        dc = done_cnt;
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(2 * N);
        check("s4_two_done", done_cnt - dc, 32'd2);
        check("s4_dout", {24'd0, dout}, 32'hFF);

        // Scenario 5: reset at bit 4 of 0x55
        dc = done_cnt; fc = ferr_cnt; pc = perr_cnt;
        d = 8'h55;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rst = 1'b1;
        rx  = 1'b1;
        evq.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2 * N);
        check("s5_dout_cleared", {24'd0, dout}, 32'h00);
        check("s5_no_pulse", (done_cnt - dc) + (ferr_cnt - fc) + (perr_cnt - pc), 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        idle(2 * N);
        check("s5_dout_next", {24'd0, dout}, 32'h81);

`ifdef UART_RX_PARITY_EN
        // Scenario 6: wrong then right parity on 0x07
        dc = done_cnt; pc = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2 * N);
        check("s6_perr", perr_cnt - pc, 32'd1);
        check("s6_no_done", done_cnt - dc, 32'd0);
        check("s6_dout_kept", {24'd0, dout}, 32'h81);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2 * N);
        check("s6_dout", {24'd0, dout}, 32'h07);
`endif

        // Randomized frames with occasional framing/parity faults and variable gaps
        for (int k = 0; k < 24; k++) begin
            d   = 8'($urandom);
            st  = ($urandom_range(0, 7) != 0);
            pok = ($urandom_range(0, 5) != 0);
            send_frame(d, st, pok);
            gap = st ? int'($urandom_range(0, N)) : N + int'($urandom_range(0, N));
            if (gap > 0) idle(gap);
        end
        idle(2 * N);
        check("queue_drained", evq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
